// File: rtl/command_wbuf.sv
// Host-to-device write buffer: the application layer fills and commits dwords,
// which are streamed to the transport layer in frames of at most MAX_FRAME_DW.
module command_wbuf #(
    parameter int DEPTH_LOG2   = 10,
    parameter int MAX_FRAME_DW = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           al_data_in,
    input  logic                  al_data_val_in,
    input  logic                  al_commit_in,
    input  logic                  al_abort_in,
    input  logic                  al_err_clr_in,
    output logic                  al_full_out,
    output logic [DEPTH_LOG2:0]   al_free_out,
    output logic                  al_busy_out,
    output logic                  al_done_out,
    output logic                  al_err_out,
    output logic [31:0]           tl_data_out,
    output logic                  tl_data_val_out,
    output logic                  tl_data_last_out,
    input  logic                  tl_data_strobe_in
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam int FW = (MAX_FRAME_DW > 1) ? $clog2(MAX_FRAME_DW) : 1;
    localparam logic [PW-1:0] ZERO_P      = {PW{1'b0}};
    localparam logic [PW-1:0] ONE_P       = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] DEPTH_P     = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [FW-1:0] ZERO_F      = {FW{1'b0}};
    localparam logic [FW-1:0] ONE_F       = {{(FW-1){1'b0}}, 1'b1};
    localparam logic [FW-1:0] FRAME_END_F = FW'(MAX_FRAME_DW - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [PW-1:0] wptr_r, wptr_s, rel_ptr_r, rel_ptr_s, rd_ptr_r, rd_ptr_s;
    logic [PW-1:0] uncom_r, uncom_s, rem_r, rem_s, rd_left_r, rd_left_s;
    logic [PW-1:0] free_r, free_s, used_s;
    logic [FW-1:0] frame_r, frame_s;
    logic          q_v_r, q_v_s, skid_v_r, skid_v_s;
    logic          last_r, last_s, busy_r, busy_s, done_r, done_s;
    logic          err_r, err_s, full_r, full_s;
    logic [31:0]   q_r, skid_r;
    logic [31:0]   mem_r [0:(2**DEPTH_LOG2)-1];
    logic          wr_ok_s, mem_we_s, pop_s, commit_ok_s, rd_issue_s, q_keep_s, err_ev_s;

    // Next-state, pointer, output-stage and flag computation
    always_comb begin
        state_s   = state_r;
        wptr_s    = wptr_r;
        rel_ptr_s = rel_ptr_r;
        rd_ptr_s  = rd_ptr_r;
        uncom_s   = uncom_r;
        rem_s     = rem_r;
        rd_left_s = rd_left_r;
        frame_s   = frame_r;
        q_v_s     = q_v_r;
        skid_v_s  = skid_v_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        err_s     = err_r;

        pop_s       = (skid_v_r | q_v_r) & tl_data_strobe_in;
        wr_ok_s     = al_data_val_in & ~full_r;
        mem_we_s    = wr_ok_s & ~al_abort_in;
        commit_ok_s = al_commit_in & ~busy_r & (uncom_r != ZERO_P);
        // The RAM register may only be overwritten if its word is consumed or moved to skid
        rd_issue_s  = ~al_abort_in & (state_r != ST_IDLE) & (rd_left_r != ZERO_P)
                      & ~(q_v_r & skid_v_r & ~pop_s);
        q_keep_s    = q_v_r & (skid_v_r | ~pop_s);
        err_ev_s    = ~al_abort_in & ((al_data_val_in & full_r) | (al_commit_in & busy_r));

        if (al_abort_in) begin
            rel_ptr_s = wptr_r;
            rd_ptr_s  = wptr_r;
            uncom_s   = ZERO_P;
            rem_s     = ZERO_P;
            rd_left_s = ZERO_P;
            frame_s   = ZERO_F;
            q_v_s     = 1'b0;
            skid_v_s  = 1'b0;
            busy_s    = 1'b0;
            state_s   = ST_IDLE;
        end else begin
            if (wr_ok_s) begin
                wptr_s  = wptr_r + ONE_P;
                uncom_s = uncom_r + ONE_P;
            end else begin
                wptr_s  = wptr_r;
                uncom_s = uncom_r;
            end

            if (commit_ok_s) begin
                rem_s     = uncom_r + {{(PW-1){1'b0}}, wr_ok_s};
                rd_left_s = uncom_r + {{(PW-1){1'b0}}, wr_ok_s};
                uncom_s   = ZERO_P;
                frame_s   = ZERO_F;
                busy_s    = 1'b1;
                state_s   = ST_FETCH;
            end else if (state_r == ST_FETCH) begin
                state_s = ST_STREAM;
            end else begin
                state_s = state_r;
            end

            if (rd_issue_s) begin
                rd_ptr_s  = rd_ptr_r + ONE_P;
                rd_left_s = rd_left_r - ONE_P;
                q_v_s     = 1'b1;
                skid_v_s  = q_keep_s;
            end else begin
                q_v_s    = q_v_r & ~(pop_s & ~skid_v_r);
                skid_v_s = skid_v_r & ~pop_s;
            end

            if (pop_s) begin
                rel_ptr_s = rel_ptr_r + ONE_P;
                rem_s     = rem_r - ONE_P;
                frame_s   = last_r ? ZERO_F : (frame_r + ONE_F);
                if (rem_r == ONE_P) begin
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    busy_s = busy_r;
                end
            end else begin
                rel_ptr_s = rel_ptr_r;
            end
        end

        last_s = ~al_abort_in & ((rem_s == ONE_P) | (frame_s == FRAME_END_F));
        used_s = wptr_s - rel_ptr_s;
        full_s = (used_s == DEPTH_P);
        free_s = DEPTH_P - used_s;

        if (err_ev_s) begin
            err_s = 1'b1;
        end else if (al_err_clr_in) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            wptr_r    <= ZERO_P;
            rel_ptr_r <= ZERO_P;
            rd_ptr_r  <= ZERO_P;
            uncom_r   <= ZERO_P;
            rem_r     <= ZERO_P;
            rd_left_r <= ZERO_P;
            frame_r   <= ZERO_F;
            q_v_r     <= 1'b0;
            skid_v_r  <= 1'b0;
            last_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            full_r    <= 1'b0;
            free_r    <= DEPTH_P;
        end else begin
            state_r   <= state_s;
            wptr_r    <= wptr_s;
            rel_ptr_r <= rel_ptr_s;
            rd_ptr_r  <= rd_ptr_s;
            uncom_r   <= uncom_s;
            rem_r     <= rem_s;
            rd_left_r <= rd_left_s;
            frame_r   <= frame_s;
            q_v_r     <= q_v_s;
            skid_v_r  <= skid_v_s;
            last_r    <= last_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            err_r     <= err_s;
            full_r    <= full_s;
            free_r    <= free_s;
        end
    end

    // Buffer RAM write port
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wptr_r[DEPTH_LOG2-1:0]] <= al_data_in;
        end
    end

    // Synchronous RAM read register and read-ahead skid register
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r    <= 32'h0000_0000;
            skid_r <= 32'h0000_0000;
        end else if (rd_issue_s) begin
            q_r    <= mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
            skid_r <= q_r;
        end
    end

    assign al_full_out      = full_r;
    assign al_free_out      = free_r;
    assign al_busy_out      = busy_r;
    assign al_done_out      = done_r;
    assign al_err_out       = err_r;
    assign tl_data_out      = skid_v_r ? skid_r : q_r;
    assign tl_data_val_out  = skid_v_r | q_v_r;
    assign tl_data_last_out = last_r;

endmodule
